// File: rtl/store_issue_unit.sv
// Store issue unit: accepts SB/SH/SW/SWL/SWR from the EXE/MEM boundary,
// turns register data into lane-aligned write data plus byte strobes,
// buffers them in a small FIFO, and issues them in program order on the
// data-SRAM-like bus while tracking writes still awaiting data_ok.
//
// Handshakes: a store op transfers on a cycle where st_valid && st_ready;
// a bus write transfers on a cycle where data_req && data_addr_ok. The
// payload outputs are held stable while data_req is high and not accepted.
module store_issue_unit #(
  parameter int DEPTH   = 2,
  parameter int MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [2:0]  st_type,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_misalign,
  output logic        data_req,
  output logic        data_wr,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  output logic        store_pending
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [OW-1:0] MAX_C   = OW'(MAX_OUT);

  localparam logic [2:0] T_SB  = 3'd0;
  localparam logic [2:0] T_SH  = 3'd1;
  localparam logic [2:0] T_SW  = 3'd2;
  localparam logic [2:0] T_SWL = 3'd3;
  localparam logic [2:0] T_SWR = 3'd4;

  logic [29:0]   mem_addr  [DEPTH];
  logic [3:0]    mem_strb  [DEPTH];
  logic [31:0]   mem_data  [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [OW-1:0] out_cnt;
  logic          misalign_q;

  logic [3:0]    enc_strb;
  logic [31:0]   enc_data;
  logic          enc_bad;
  logic          accept, push, pop, ack;
  logic [1:0]    a;

  assign a        = st_addr[1:0];
  assign st_ready = (count < DEPTH_C);
  assign accept   = st_valid && st_ready;
  assign push     = accept && !enc_bad;
  assign data_req = (count != '0) && (out_cnt < MAX_C);
  assign pop      = data_req && data_addr_ok;
  // data_ok with nothing outstanding is a bus glitch; ignore it.
  assign ack      = data_data_ok && (out_cnt != '0);

  // Byte-lane placement and strobe generation for the presented store.
  always_comb begin
    enc_strb = 4'b0000;
    enc_data = 32'h0;
    enc_bad  = 1'b0;
    case (st_type)
      T_SB: begin
        enc_strb = 4'b0001 << a;
        enc_data = {4{st_data[7:0]}};
      end
      T_SH: begin
        enc_strb = a[1] ? 4'b1100 : 4'b0011;
        enc_data = {2{st_data[15:0]}};
        enc_bad  = a[0];
      end
      T_SW: begin
        enc_strb = 4'b1111;
        enc_data = st_data;
        enc_bad  = (a != 2'd0);
      end
      T_SWL: begin
        case (a)
          2'd0:    begin enc_strb = 4'b0001; enc_data = {24'h0, st_data[31:24]}; end
          2'd1:    begin enc_strb = 4'b0011; enc_data = {16'h0, st_data[31:16]}; end
          2'd2:    begin enc_strb = 4'b0111; enc_data = {8'h0, st_data[31:8]};   end
          default: begin enc_strb = 4'b1111; enc_data = st_data;                 end
        endcase
      end
      T_SWR: begin
        enc_strb = 4'b1111 << a;
        enc_data = st_data << {a, 3'b000};
      end
      default: enc_bad = 1'b1;
    endcase
  end

  // FIFO storage; contents are only observed through the gated head below.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= st_addr[31:2];
      mem_strb[wr_ptr] <= enc_strb;
      mem_data[wr_ptr] <= enc_data;
    end
  end

  // FIFO pointers, occupancy, outstanding-write count and misalign pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      out_cnt    <= '0;
      misalign_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count      <= count + CW'(push) - CW'(pop);
      out_cnt    <= out_cnt + OW'(pop) - OW'(ack);
      misalign_q <= accept && enc_bad;
    end
  end

  assign st_misalign   = misalign_q;
  assign data_wr       = data_req;
  assign data_addr     = data_req ? {mem_addr[rd_ptr], 2'b00} : 32'h0;
  assign data_wstrb    = data_req ? mem_strb[rd_ptr] : 4'h0;
  assign data_wdata    = data_req ? mem_data[rd_ptr] : 32'h0;
  assign store_pending = (count != '0) || (out_cnt != '0);

endmodule

// File: tb/tb_store_issue_unit.sv
// Bench for store_issue_unit: a queue-based reference model of the store
// path checked against the DUT every cycle, plus directed sequences that
// pin the model with hand-computed literal values.
module tb_store_issue_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [2:0]  st_type = 3'd0;
  logic [31:0] st_addr = 32'h0;
  logic [31:0] st_data = 32'h0;
  logic        st_misalign;
  logic        data_req, data_wr;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok = 1'b0;
  logic        data_data_ok = 1'b0;
  logic        store_pending;

  int n_chk  = 0;
  int n_fail = 0;

  // model state: pending writes {addr, strb, data}, outstanding count, pulse
  logic [67:0] exp_q[$];
  int          out_m = 0;
  logic        mis_m = 1'b0;
  int          o_next;
  logic        ready_m, req_m;
  logic [35:0] lit_tab[8];

  store_issue_unit #(.DEPTH(2), .MAX_OUT(2)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_type(st_type),
    .st_addr(st_addr), .st_data(st_data), .st_misalign(st_misalign),
    .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .store_pending(store_pending)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_bad(input logic [2:0] t, input logic [31:0] ad);
    int a;
    a = int'(ad[1:0]);
    if (t > 3'd4) return 1'b1;
    if (t == 3'd1 && (a % 2) != 0) return 1'b1;
    if (t == 3'd2 && a != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Expected bus beat from the store rules, by lane arithmetic.
  function automatic logic [67:0] model_enc(input logic [2:0] t, input logic [31:0] ad,
                                            input logic [31:0] rt);
    int a;
    logic [31:0] strb32, d;
    a = int'(ad[1:0]);
    strb32 = 0;
    d = 0;
    case (t)
      3'd0: begin strb32 = 32'd1 << a; d = 32'(rt[7:0]) * 32'h01010101; end
      3'd1: begin strb32 = 32'd3 << a; d = 32'(rt[15:0]) * 32'h00010001; end
      3'd2: begin strb32 = 32'd15; d = rt; end
      3'd3: begin strb32 = (32'd1 << (a + 1)) - 1; d = rt >> (8 * (3 - a)); end
      default: begin strb32 = (32'd15 << a) & 32'd15; d = rt << (8 * a); end
    endcase
    return {ad & 32'hFFFF_FFFC, strb32[3:0], d};
  endfunction

  // reference model update
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      out_m = 0;
      mis_m = 1'b0;
    end else begin
      ready_m = (exp_q.size() < 2);
      req_m   = (exp_q.size() != 0) && (out_m < 2);
      o_next  = out_m;
      if (req_m && data_addr_ok) begin
        void'(exp_q.pop_front());
        o_next++;
      end
      if (data_data_ok && out_m > 0) o_next--;
      out_m = o_next;
      mis_m = 1'b0;
      if (st_valid && ready_m) begin
        if (is_bad(st_type, st_addr)) mis_m = 1'b1;
        else exp_q.push_back(model_enc(st_type, st_addr, st_data));
      end
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (!rst) begin
      check("rst_req", 68'(data_req), 68'd0);
      check("rst_pending", 68'(store_pending), 68'd0);
      check("rst_misalign", 68'(st_misalign), 68'd0);
    end else begin
      check("ready", 68'(st_ready), 68'(exp_q.size() < 2));
      check("req", 68'(data_req), 68'((exp_q.size() != 0) && (out_m < 2)));
      check("wr", 68'(data_wr), 68'(data_req));
      check("pending", 68'(store_pending), 68'((exp_q.size() != 0) || (out_m != 0)));
      check("misalign", 68'(st_misalign), 68'(mis_m));
      if (exp_q.size() != 0 && out_m < 2)
        check("payload", {data_addr, data_wstrb, data_wdata}, exp_q[0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] t, input logic [31:0] ad, input logic [31:0] d);
    st_valid = 1'b1;
    st_type  = t;
    st_addr  = ad;
    st_data  = d;
  endtask

  initial begin
    lit_tab[0] = {4'b0001, 32'h00000011};
    lit_tab[1] = {4'b0011, 32'h00001122};
    lit_tab[2] = {4'b0111, 32'h00112233};
    lit_tab[3] = {4'b1111, 32'h11223344};
    lit_tab[4] = {4'b1111, 32'h11223344};
    lit_tab[5] = {4'b1110, 32'h22334400};
    lit_tab[6] = {4'b1100, 32'h33440000};
    lit_tab[7] = {4'b1000, 32'h44000000};

    // reset
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("lit_reset_ready", 68'(st_ready), 68'd1);
    check("lit_reset_req", 68'(data_req), 68'd0);
    check("lit_reset_pending", 68'(store_pending), 68'd0);

    // SB with addr_ok tied high
    data_addr_ok = 1'b1;
    drive(3'd0, 32'h0000_1003, 32'h1234_56AB);
    tick();
    st_valid = 1'b0;
    check("lit_sb_req", 68'(data_req), 68'd1);
    check("lit_sb_beat", {data_addr, data_wstrb, data_wdata},
          {32'h0000_1000, 4'b1000, 32'hABAB_ABAB});
    tick();
    check("lit_sb_wait_pending", 68'(store_pending), 68'd1);
    data_data_ok = 1'b1;
    tick();
    data_data_ok = 1'b0;
    check("lit_sb_done_pending", 68'(store_pending), 68'd0);

    // SWL / SWR sweep
    data_data_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive((i < 4) ? 3'd3 : 3'd4, 32'h0000_3000 + 32'(i % 4), 32'h1122_3344);
      tick();
      st_valid = 1'b0;
      check("lit_sweep", 68'({data_wstrb, data_wdata}), 68'(lit_tab[i]));
      tick();
    end
    repeat (3) tick();
    data_data_ok = 1'b0;

    // backpressure
    data_addr_ok = 1'b0;
    drive(3'd2, 32'h0000_4000, 32'hAAAA_0001);
    tick();
    drive(3'd2, 32'h0000_4004, 32'hAAAA_0002);
    tick();
    check("lit_bp_ready_low", 68'(st_ready), 68'd0);
    drive(3'd2, 32'h0000_4008, 32'hAAAA_0003);
    for (int i = 0; i < 3; i++) begin
      check("lit_bp_stable", {data_req, data_addr, data_wstrb, data_wdata},
            {1'b1, 32'h0000_4000, 4'b1111, 32'hAAAA_0001});
      tick();
    end
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    check("lit_bp_ready_back", 68'(st_ready), 68'd1);
    check("lit_bp_next", {data_addr, data_wdata}, {32'h0000_4004, 32'hAAAA_0002});
    tick();
    st_valid = 1'b0;
    check("lit_bp_third_taken", 68'(st_ready), 68'd0);
    data_addr_ok = 1'b1;
    data_data_ok = 1'b1;
    repeat (8) tick();
    check("lit_bp_drained", 68'(store_pending), 68'd0);
    data_data_ok = 1'b0;

    // outstanding limit
    drive(3'd2, 32'h0000_5000, 32'h5555_0001);
    tick();
    drive(3'd2, 32'h0000_5004, 32'h5555_0002);
    tick();
    drive(3'd2, 32'h0000_5008, 32'h5555_0003);
    tick();
    st_valid = 1'b0;
    check("lit_lim_req_low", 68'(data_req), 68'd0);
    repeat (2) tick();
    check("lit_lim_still_low", 68'(data_req), 68'd0);
    data_data_ok = 1'b1;
    tick();
    data_data_ok = 1'b0;
    check("lit_lim_third", {data_req, data_addr}, {1'b1, 32'h0000_5008});
    drive(3'd2, 32'h0000_500C, 32'h5555_0004);
    tick();
    st_valid = 1'b0;
    check("lit_lim_full_again", 68'(data_req), 68'd0);
    data_data_ok = 1'b1;
    tick();
    check("lit_lim_fourth", {data_req, data_addr}, {1'b1, 32'h0000_500C});
    tick();
    data_data_ok = 1'b0;
    check("lit_lim_both_same_cycle", {data_req, store_pending}, {1'b0, 1'b1});
    data_data_ok = 1'b1;
    repeat (3) tick();
    data_data_ok = 1'b0;
    check("lit_lim_drained", 68'(store_pending), 68'd0);

    // misaligned ops and a spurious data_ok
    drive(3'd1, 32'h0000_2001, 32'hDEAD_BEEF);
    tick();
    check("lit_sh_mis", {st_misalign, data_req, store_pending}, {1'b1, 1'b0, 1'b0});
    drive(3'd2, 32'h0000_2002, 32'hDEAD_BEEF);
    tick();
    st_valid = 1'b0;
    check("lit_sw_mis", {st_misalign, data_req, store_pending}, {1'b1, 1'b0, 1'b0});
    tick();
    check("lit_mis_pulse_end", 68'(st_misalign), 68'd0);
    data_data_ok = 1'b1;
    tick();
    data_data_ok = 1'b0;
    drive(3'd0, 32'h0000_2000, 32'h0000_0077);
    tick();
    st_valid = 1'b0;
    check("lit_after_spurious_req", 68'(data_req), 68'd1);
    tick();
    data_data_ok = 1'b1;
    tick();
    data_data_ok = 1'b0;
    check("lit_after_spurious_idle", 68'(store_pending), 68'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      st_valid     = ($urandom_range(0, 99) < 60);
      st_type      = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                                 : 3'($urandom_range(0, 4));
      st_addr      = $urandom;
      st_data      = $urandom;
      data_addr_ok = ($urandom_range(0, 99) < 55);
      data_data_ok = ($urandom_range(0, 99) < 45);
      tick();
    end
    st_valid     = 1'b0;
    data_addr_ok = 1'b1;
    data_data_ok = 1'b1;
    repeat (10) tick();
    check("lit_random_drained", 68'(store_pending), 68'd0);

    // reset with two buffered and one outstanding
    data_data_ok = 1'b0;
    drive(3'd2, 32'h0000_6000, 32'h6666_0001);
    tick();
    drive(3'd2, 32'h0000_6004, 32'h6666_0002);
    tick();
    data_addr_ok = 1'b0;
    drive(3'd2, 32'h0000_6008, 32'h6666_0003);
    tick();
    st_valid = 1'b0;
    check("lit_pre_rst_pending", {data_req, store_pending}, {1'b1, 1'b1});
    #2 rst = 1'b0;
    #1;
    check("lit_rst_async", {data_req, store_pending, st_misalign}, {1'b0, 1'b0, 1'b0});
    tick();
    rst = 1'b1;
    data_addr_ok = 1'b1;
    data_data_ok = 1'b1;
    tick();
    check("lit_post_rst", {st_ready, data_req, store_pending}, {1'b1, 1'b0, 1'b0});
    repeat (3) tick();
    check("lit_post_rst_quiet", 68'(data_req), 68'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
